// File: rtl/alu_result_bcd_converter.sv
// Sequential double-dabble converter: turns the ALU result Z into sign + packed BCD.
// One bit per clock, with a valid/ready handshake on each side.
module alu_result_bcd_converter #(
  parameter int unsigned IN_WIDTH = 16,
  parameter int unsigned DIGITS   = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_WIDTH-1:0]   in_data,
  input  logic                  in_signed,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIGITS*4-1:0]   out_bcd,
  output logic                  out_neg,
  output logic                  busy
);

  localparam int unsigned BcdW  = DIGITS * 4;
  localparam int unsigned WorkW = BcdW + IN_WIDTH;
  localparam int unsigned CntW  = $clog2(IN_WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e            state_q, state_d;
  logic [WorkW-1:0]  work_q, work_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic [BcdW-1:0]   out_bcd_q, out_bcd_d;
  logic              out_neg_q, out_neg_d;
  logic              out_valid_q, out_valid_d;

  logic              is_neg;
  logic [IN_WIDTH-1:0] mag;
  logic [WorkW-1:0]  adj;
  logic [WorkW-1:0]  shifted;

  // Negating 0x8000 yields 0x8000, which read unsigned is the wanted 32768.
  assign is_neg = in_signed & in_data[IN_WIDTH-1];
  assign mag    = is_neg ? -in_data : in_data;

  always_comb begin
    adj = work_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (adj[IN_WIDTH+4*i +: 4] >= 4'd5) begin
        adj[IN_WIDTH+4*i +: 4] = adj[IN_WIDTH+4*i +: 4] + 4'd3;
      end
    end
    shifted = {adj[WorkW-2:0], 1'b0};
  end

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    cnt_d       = cnt_q;
    neg_d       = neg_q;
    out_bcd_d   = out_bcd_q;
    out_neg_d   = out_neg_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          work_d  = {{BcdW{1'b0}}, mag};
          neg_d   = is_neg;
          cnt_d   = CntW'(IN_WIDTH);
          state_d = StShift;
        end
      end
      StShift: begin
        work_d = shifted;
        cnt_d  = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          out_bcd_d   = shifted[WorkW-1 -: BcdW];
          out_neg_d   = neg_q;
          out_valid_d = 1'b1;
          state_d     = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      work_q      <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      out_bcd_q   <= '0;
      out_neg_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      cnt_q       <= cnt_d;
      neg_q       <= neg_d;
      out_bcd_q   <= out_bcd_d;
      out_neg_q   <= out_neg_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == StIdle) && !rst;
  assign busy      = (state_q == StShift);
  assign out_valid = out_valid_q;
  assign out_bcd   = out_bcd_q;
  assign out_neg   = out_neg_q;

endmodule

// File: tb/tb_alu_result_bcd_converter.sv
// Scoreboard bench for alu_result_bcd_converter: a decimal reference model feeds a queue
// on every input handshake; results are popped on every output handshake.
module tb_alu_result_bcd_converter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_signed;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] out_bcd;
  logic        out_neg;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int n_out = 0;
  int last_acc = 0;
  bit prev_ov = 1'b0;
  logic [20:0] sb[$];

  alu_result_bcd_converter #(
    .IN_WIDTH (16),
    .DIGITS   (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_signed (in_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bcd   (out_bcd),
    .out_neg   (out_neg),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: {neg, 5 BCD digits} computed by decimal division.
  function automatic logic [20:0] model(input logic [15:0] d, input logic s);
    logic [20:0] r;
    int m;
    r = '0;
    m = (s && d[15]) ? 65536 - int'(d) : int'(d);
    r[20] = s && d[15];
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      prev_ov = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        sb.push_back(model(in_data, in_signed));
        last_acc = cyc + 1;
      end
      if (out_valid && !prev_ov) check_eq("latency", cyc - last_acc, 16);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_eq("sb_extra", {31'd0, out_valid}, 0);
        end else begin
          logic [20:0] e;
          e = sb.pop_front();
          check_eq("sb_bcd", {12'd0, out_bcd}, {12'd0, e[19:0]});
          check_eq("sb_neg", {31'd0, out_neg}, {31'd0, e[20]});
        end
        n_out++;
      end
      prev_ov = out_valid;
    end
  end

  // Called at posedge+2; returns just after the accepting edge (posedge+2).
  task automatic send(input logic [15:0] d, input logic s, input bit hold, output int acc_e);
    bit ok = 1'b0;
    acc_e = 0;
    in_valid  = 1'b1;
    in_data   = d;
    in_signed = s;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        acc_e = cyc + 1;
        break;
      end
    end
    if (!ok) check_eq("accept_timeout", {31'd0, in_ready}, 1);
    @(posedge clk);
    #2;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int start = n_out;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #2;
      if (n_out > start) break;
    end
    check_eq("done_timeout", n_out, start + 1);
  endtask

  task automatic run(input logic [15:0] d, input logic s, input logic [19:0] eb, input logic en,
                     input string tag);
    int e;
    send(d, s, 1'b0, e);
    wait_done();
    check_eq({tag, "_bcd"}, {12'd0, out_bcd}, {12'd0, eb});
    check_eq({tag, "_neg"}, {31'd0, out_neg}, {31'd0, en});
  endtask

  initial begin
    int e1, e2;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_signed = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check_eq("rst_in_ready", {31'd0, in_ready}, 0);
    check_eq("rst_out_valid", {31'd0, out_valid}, 0);
    check_eq("rst_out_bcd", {12'd0, out_bcd}, 0);
    check_eq("rst_out_neg", {31'd0, out_neg}, 0);
    check_eq("rst_busy", {31'd0, busy}, 0);
    rst = 1'b0;
    #1;
    check_eq("idle_in_ready", {31'd0, in_ready}, 1);
    @(posedge clk);
    #2;

    run(16'd112, 1'b0, 20'h00112, 1'b0, "d112");
    check_eq("ov_one_cycle", {31'd0, out_valid}, 0);
    run(16'hFFFF, 1'b0, 20'h65535, 1'b0, "ffff_u");
    run(16'hFFFF, 1'b1, 20'h00001, 1'b1, "ffff_s");
    run(16'h8000, 1'b1, 20'h32768, 1'b1, "8000_s");
    run(16'd14400, 1'b0, 20'h14400, 1'b0, "d14400");
    run(16'd0, 1'b0, 20'h00000, 1'b0, "zero_u");
    run(16'd0, 1'b1, 20'h00000, 1'b0, "zero_s");
    run(16'd32767, 1'b1, 20'h32767, 1'b0, "7fff_s");

    // Backpressure: result must hold while the consumer stalls; stray input ignored.
    out_ready = 1'b0;
    send(16'd500, 1'b0, 1'b0, e1);
    for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
    check_eq("bp_valid_rise", {31'd0, out_valid}, 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #2;
      in_valid = (i == 3);
      in_data  = 16'd99;
      @(negedge clk);
      check_eq("bp_valid", {31'd0, out_valid}, 1);
      check_eq("bp_bcd", {12'd0, out_bcd}, 32'h00500);
      check_eq("bp_neg", {31'd0, out_neg}, 0);
      check_eq("bp_in_ready", {31'd0, in_ready}, 0);
    end
    @(posedge clk);
    #2;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_done();
    check_eq("hold_valid", {31'd0, out_valid}, 0);
    check_eq("hold_bcd", {12'd0, out_bcd}, 32'h00500);
    run(16'd7, 1'b0, 20'h00007, 1'b0, "after_bp");

    // Reset in the middle of a conversion.
    send(16'd255, 1'b0, 1'b0, e1);
    repeat (7) @(posedge clk);
    #2;
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort_busy_before", {31'd0, busy}, 1);
    check_eq("abort_in_ready", {31'd0, in_ready}, 0);
    @(posedge clk);
    #2;
    check_eq("abort_valid", {31'd0, out_valid}, 0);
    check_eq("abort_busy", {31'd0, busy}, 0);
    check_eq("abort_bcd", {12'd0, out_bcd}, 0);
    rst = 1'b0;
    run(16'd255, 1'b0, 20'h00255, 1'b0, "d255");

    // Back-to-back with in_valid held high.
    send(16'd3, 1'b0, 1'b1, e1);
    send(16'd15, 1'b0, 1'b0, e2);
    check_eq("b2b_spacing", e2 - e1, 18);
    wait_done();
    check_eq("b2b_last_bcd", {12'd0, out_bcd}, 32'h00015);
    check_eq("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_result_bcd_converter.md
Name: alu_result_bcd_converter

Overview:
- Downstream consumer of the ALU arithmetic stage. Takes the 16-bit result Z and converts it to packed BCD digits plus a sign flag for the display and readout logic.
- Sequential shift-add-3 (double-dabble) engine: one bit per clock.
- Valid/ready handshake on both input and output, so the ALU and display sides can stall independently.

Parameters:
IN_WIDTH, 16, width of the binary input (matches ALU Z width)
DIGITS, 5, number of BCD output digits; must satisfy DIGITS >= ceil(IN_WIDTH*log10(2)) (5 covers 65535)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  in_data/in_signed are valid
in_ready  out  1  converter can accept a new value
in_data  in  IN_WIDTH  binary value (ALU Z)
in_signed  in  1  1 = treat in_data as two's complement
out_valid  out  1  out_bcd/out_neg hold a completed result
out_ready  in  1  consumer accepts the result
out_bcd  out  DIGITS*4  packed BCD, digit 0 in bits [3:0]
out_neg  out  1  result is negative (sign-magnitude)
busy  out  1  conversion in progress (state SHIFT)

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, out_valid=0, out_bcd=0, out_neg=0, busy=0, bit counter=0.
  - in_ready=0 while rst is high.
  - Reset mid-conversion aborts it. No partial result is ever presented.
- States and transitions:
  - IDLE: in_ready=1. On an edge with in_valid&&in_ready, capture the value → SHIFT, counter=IN_WIDTH.
  - SHIFT: busy=1, in_ready=0. Each cycle:
    - add 3 to every BCD digit of the working register that is >=5;
    - then shift {bcd, bin} left by 1;
    - decrement the counter.
  - SHIFT → DONE: on the edge where the counter goes 1→0. On that same edge, load out_bcd and out_neg and set out_valid=1.
  - DONE: out_valid=1, in_ready=0, outputs stable. On an edge with out_valid&&out_ready: out_valid=0 → IDLE.
  - No same-cycle accept of new input in DONE; in_ready returns 1 the cycle after the output handshake.
- Capture rules:
  - in_signed=1 and in_data[MSB]=1: magnitude = two's-complement negation of in_data, taken as an unsigned IN_WIDTH value (0x8000 → 32768); out_neg=1.
  - Otherwise magnitude = in_data; out_neg=0.
  - Zero is never reported negative.
- Latency: out_valid rises on the IN_WIDTH-th edge after the accepting edge (16 cycles at default). Throughput is one conversion per IN_WIDTH+2 cycles with out_ready held high.
- Output holding:
  - out_bcd/out_neg change only on the completion edge or on reset.
  - After the output handshake they keep the last result (out_valid=0) until the next completion.
- Ignored inputs:
  - in_valid outside IDLE is ignored and not queued.
  - out_ready is ignored while out_valid=0.
- Width: the working register is DIGITS*4+IN_WIDTH bits. The digit adjust is a 4-bit add. No overflow is possible given the DIGITS constraint.
- All outputs are registered except in_ready and busy, which decode from state (in_ready also gated by rst).

Test Plan:
- in_data=112, in_signed=0, out_ready=1 → out_bcd=0x00112, out_neg=0; out_valid high exactly 16 cycles after the accept edge, for one cycle.
- in_data=0xFFFF unsigned → out_bcd=0x65535, out_neg=0. in_data=0xFFFF signed → out_bcd=0x00001, out_neg=1. in_data=0x8000 signed → 0x32768, out_neg=1.
- in_data=14400 (120*120), then 0 → out_bcd=0x14400, then 0x00000 with out_neg=0 (also for 0 with in_signed=1).
- Backpressure: out_ready=0 for 10 cycles after completion → out_valid, out_bcd and out_neg stable; in_ready=0; an in_valid pulse with 99 is ignored; after out_ready=1, the next accepted value converts normally.
- rst asserted 8 cycles into a conversion of 255 → next edge out_valid=0, busy=0, out_bcd=0. After release, convert 255 → 0x00255 in 16 cycles.
- Back-to-back with out_ready tied 1, in_valid held high with 3 then 15 → results 0x00003 then 0x00015 in order. The second accept occurs 18 cycles after the first.
